lsm_manager: RTL and testbench
==============================

Name: lsm_manager

Overview:
- Load/store-multiple sequencer that feeds the microprogrammed control unit's LSM_DETECT and LSM_END status inputs.
- Latches the 16-bit register list from IR and walks it in ascending register order, presenting one register number at a time to the register-file port mux.
- Computes the transfer count, the start-address adjustment for the IA/IB/DA/DB modes, and the writeback offset for the address datapath.
- Driven each cycle by the control unit's LSM_EN and LSM_IN[2:0] control-word fields.

Parameters:
- LIST_W, 16, register-list width (IR[15:0]); fixed at 16 for ARM; REG_SEL width is log2(LIST_W).

Ports:
- CLK  input  1  system clock, rising edge
- RESET  input  1  synchronous, active-high reset
- IR  input  32  instruction register; uses [15:0] list, [23] U, [24] P
- LSM_EN  input  1  command qualifier from control word; LSM_IN is ignored when 0
- LSM_IN  input  3  command: 000 HOLD, 001 START, 010 NEXT, 111 ABORT; others behave as HOLD
- LSM_DETECT  output  1  a listed register is selected and waiting for transfer
- LSM_END  output  1  list exhausted; sequence complete
- REG_SEL  output  4  register number of the current transfer
- REG_COUNT  output  5  number of set bits in the latched list (0-16)
- START_OFFSET  output  8  two's-complement byte offset added to the base for the first address
- WB_OFFSET  output  7  4*REG_COUNT, used for base writeback

Behaviour:
- Reset (synchronous): state IDLE; list=0; idx=0; all outputs 0.
- Registered state: list[15:0], idx[3:0], count[4:0], P and U bits, and state (IDLE, SCAN, FOUND, DONE). All outputs are decoded from registered state only; no combinational path from input to output.
- IDLE: on LSM_EN && START, latch list=IR[15:0], P=IR[24], U=IR[23], count=popcount(IR[15:0]), and idx=0. Go to SCAN, or to DONE when the list is 0.
- SCAN (bit-serial): each cycle, test list[idx].
  - Bit set: go to FOUND, holding idx.
  - Bit clear and idx<15: idx+=1.
  - Bit clear and idx==15: go to DONE.
- FOUND: LSM_DETECT=1 and REG_SEL=idx. Hold until LSM_EN && NEXT, then clear list[idx].
  - If the remaining list is 0, go to DONE.
  - Otherwise idx+=1 and go to SCAN.
- DONE: LSM_END=1 and LSM_DETECT=0. Hold until LSM_EN && START (restart with the new IR) or ABORT.
- ABORT (LSM_EN && 111), from any state: go to IDLE next cycle, clear list, and drop LSM_DETECT and LSM_END.
- START while not in IDLE or DONE: treated as ABORT followed by restart in the same cycle (relatch and go to SCAN).
- NEXT outside FOUND: ignored.
- idx never wraps past 15.
- START_OFFSET by {P,U}, held stable from START until the next START or ABORT:
  - IA (01): 0
  - IB (11): +4
  - DA (00): -4*count+4
  - DB (10): -4*count
- WB_OFFSET = {count,2'b00}. REG_COUNT = count.
- Latency: START to first LSM_DETECT = 1 + index of the lowest set bit + 1 cycles. NEXT to the following LSM_DETECT = gap to the next set bit + 1 cycles.

Optional Feature:
- Macro LSM_FASTSCAN_EN.
- Defined: SCAN locates the lowest set bit of list in one cycle using a priority encoder. START to LSM_DETECT is exactly 2 cycles, and NEXT to LSM_DETECT is 2 cycles, independent of gaps.
- Undefined: the bit-serial scan described above.
- Register order, offsets and END timing relative to the last NEXT (2 cycles) are identical in both builds.

Decomposition:
- Shared package lsm_pkg holds:
  - LSM_IN command constants (LSM_HOLD, LSM_START, LSM_NEXT, LSM_ABORT)
  - state encoding
  - mode codes IA/IB/DA/DB
- One natural sub-module: lsm_prio_enc, a 16-to-4 lowest-set-bit encoder with a valid flag. It is used by the fast-scan build and for the list-empty test.

Test Plan:
- Reset, then START with IR[15:0]=16'h0000 and P=0, U=1. Required: LSM_END=1 two cycles later, REG_COUNT=0, WB_OFFSET=0, LSM_DETECT never asserted.
- START with list 16'h8005 and IA, issuing NEXT one cycle after each LSM_DETECT. Required: REG_SEL sequence 0, 2, 15; REG_COUNT=3; WB_OFFSET=12; START_OFFSET=0; LSM_END after the third NEXT.
- START with list 16'h00F0 in DB and in DA. Required: START_OFFSET=8'hF0 (-16) for DB and 8'hF4 (-12) for DA; first REG_SEL=4; bit-serial build asserts DETECT 6 cycles after START.
- ABORT while in FOUND with REG_SEL=2. Required: next cycle LSM_DETECT=0, LSM_END=0, state IDLE; a subsequent START with 16'h0001 yields REG_SEL=0.
- Hold LSM_IN=NEXT with LSM_EN=0 for 5 cycles while in FOUND. Required: REG_SEL and LSM_DETECT stay unchanged.
- With LSM_FASTSCAN_EN defined, list 16'h8001. Required: DETECT with REG_SEL=0 two cycles after START; after NEXT, DETECT with REG_SEL=15 two cycles later.

Source files
------------

// File: rtl/lsm_pkg.sv
// Shared definitions for the load/store-multiple sequencer: command codes,
// FSM state encoding, addressing-mode codes and offset/popcount helpers.
package lsm_pkg;

  localparam int LIST_W = 16;
  localparam int SEL_W  = $clog2(LIST_W);
  localparam int CNT_W  = SEL_W + 1;

  localparam logic [2:0] LSM_HOLD  = 3'b000;
  localparam logic [2:0] LSM_START = 3'b001;
  localparam logic [2:0] LSM_NEXT  = 3'b010;
  localparam logic [2:0] LSM_ABORT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SCAN  = 2'b01,
    ST_FOUND = 2'b10,
    ST_DONE  = 2'b11
  } lsm_state_e;

  // Mode codes are {P,U} from IR[24:23]
  localparam logic [1:0] MODE_IA = 2'b01;
  localparam logic [1:0] MODE_IB = 2'b11;
  localparam logic [1:0] MODE_DA = 2'b00;
  localparam logic [1:0] MODE_DB = 2'b10;

  function automatic logic [CNT_W-1:0] popcount16(input logic [LIST_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = {CNT_W{1'b0}};
    for (int i = 0; i < LIST_W; i++) begin
      c = c + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  function automatic logic [7:0] start_offset(input logic [1:0] mode,
                                              input logic [CNT_W-1:0] cnt);
    logic [7:0] bytes;
    logic [7:0] res;
    bytes = {1'b0, cnt, 2'b00};
    case (mode)
      MODE_IA: res = 8'd0;
      MODE_IB: res = 8'd4;
      MODE_DA: res = 8'd4 - bytes;
      MODE_DB: res = 8'd0 - bytes;
      default: res = 8'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsm_prio_enc.sv
// Lowest-set-bit encoder over the register list, with a non-empty flag.
module lsm_prio_enc
  import lsm_pkg::*;
(
  input  logic [LIST_W-1:0] i_vec,
  output logic [SEL_W-1:0]  o_idx,
  output logic              o_valid
);

  logic [SEL_W-1:0] w_idx;
  logic             w_valid;

  // Walk from the top so the lowest set bit is the last one to win
  always_comb begin
    w_idx   = {SEL_W{1'b0}};
    w_valid = 1'b0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      w_idx   = i_vec[i] ? SEL_W'(i) : w_idx;
      w_valid = w_valid | i_vec[i];
    end
  end

  assign o_idx   = w_idx;
  assign o_valid = w_valid;

endmodule

// File: rtl/lsm_manager.sv
// Load/store-multiple sequencer: walks the IR register list in ascending order.
// Optional macro LSM_FASTSCAN_EN replaces the bit-serial scan with a one-cycle priority search.
module lsm_manager
  import lsm_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       IR,
  input  logic              LSM_EN,
  input  logic [2:0]        LSM_IN,
  output logic              LSM_DETECT,
  output logic              LSM_END,
  output logic [SEL_W-1:0]  REG_SEL,
  output logic [CNT_W-1:0]  REG_COUNT,
  output logic [7:0]        START_OFFSET,
  output logic [6:0]        WB_OFFSET
);

  lsm_state_e        r_state, w_state_nxt;
  logic [LIST_W-1:0] r_list, w_list_nxt, w_list_cleared, w_enc_in;
  logic [SEL_W-1:0]  r_idx, w_idx_nxt, w_enc_idx;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic [7:0]        r_start_off, w_start_off_nxt;
  logic              w_enc_valid;
  logic              w_start, w_next, w_abort;
  logic              w_unused_bits;

  // Command decode; LSM_EN qualifies every command
  always_comb begin
    w_start = 1'b0;
    w_next  = 1'b0;
    w_abort = 1'b0;
    case (LSM_IN)
      LSM_HOLD:  w_start = 1'b0;
      LSM_START: w_start = LSM_EN;
      LSM_NEXT:  w_next  = LSM_EN;
      LSM_ABORT: w_abort = LSM_EN;
      default:   w_start = 1'b0;
    endcase
  end

  // In FOUND the encoder looks at the list minus the current bit, so it
  // answers "anything left?" for the NEXT decision.
  assign w_list_cleared = r_list & ~(16'h0001 << r_idx);
  assign w_enc_in       = (r_state == ST_FOUND) ? w_list_cleared : r_list;

  lsm_prio_enc u_prio_enc (
    .i_vec   (w_enc_in),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_valid)
  );

  // Next-state and datapath update
  always_comb begin
    w_state_nxt     = r_state;
    w_list_nxt      = r_list;
    w_idx_nxt       = r_idx;
    w_count_nxt     = r_count;
    w_start_off_nxt = r_start_off;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
      w_list_nxt  = 16'h0000;
      w_idx_nxt   = 4'd0;
    end else if (w_start) begin
      w_list_nxt      = IR[15:0];
      w_idx_nxt       = 4'd0;
      w_count_nxt     = popcount16(IR[15:0]);
      w_start_off_nxt = start_offset(IR[24:23], popcount16(IR[15:0]));
      w_state_nxt     = (IR[15:0] == 16'h0000) ? ST_DONE : ST_SCAN;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_SCAN: begin
`ifdef LSM_FASTSCAN_EN
          if (w_enc_valid) begin
            w_state_nxt = ST_FOUND;
            w_idx_nxt   = w_enc_idx;
          end else begin
            w_state_nxt = ST_DONE;
          end
`else
          if (r_list[r_idx]) begin
            w_state_nxt = ST_FOUND;
          end else if (r_idx != 4'd15) begin
            w_idx_nxt = r_idx + 4'd1;
          end else begin
            w_state_nxt = ST_DONE;
          end
`endif
        end
        ST_FOUND: begin
          if (w_next) begin
            w_list_nxt = w_list_cleared;
            if (w_enc_valid) begin
              w_state_nxt = ST_SCAN;
              w_idx_nxt   = (r_idx == 4'd15) ? 4'd15 : r_idx + 4'd1;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end else begin
            w_state_nxt = ST_FOUND;
          end
        end
        ST_DONE: w_state_nxt = ST_DONE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_list      <= 16'h0000;
      r_idx       <= 4'd0;
      r_count     <= 5'd0;
      r_start_off <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_list      <= w_list_nxt;
      r_idx       <= w_idx_nxt;
      r_count     <= w_count_nxt;
      r_start_off <= w_start_off_nxt;
    end
  end

  assign LSM_DETECT   = (r_state == ST_FOUND);
  assign LSM_END      = (r_state == ST_DONE);
  assign REG_SEL      = (r_state == ST_FOUND) ? r_idx : 4'd0;
  assign REG_COUNT    = r_count;
  assign START_OFFSET = r_start_off;
  assign WB_OFFSET    = {r_count, 2'b00};

  assign w_unused_bits = ^{IR[31:25], IR[22:16], w_enc_idx};

endmodule

// File: tb/tb_lsm_manager.sv
// Directed scoreboard bench for lsm_manager (bit-serial or LSM_FASTSCAN_EN build).
module tb_lsm_manager;
  import lsm_pkg::*;

`ifdef LSM_FASTSCAN_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    int sel;
    int lat;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] IR;
  logic        LSM_EN;
  logic [2:0]  LSM_IN;
  logic        LSM_DETECT;
  logic        LSM_END;
  logic [3:0]  REG_SEL;
  logic [4:0]  REG_COUNT;
  logic [7:0]  START_OFFSET;
  logic [6:0]  WB_OFFSET;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  lsm_manager dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .IR           (IR),
    .LSM_EN       (LSM_EN),
    .LSM_IN       (LSM_IN),
    .LSM_DETECT   (LSM_DETECT),
    .LSM_END      (LSM_END),
    .REG_SEL      (REG_SEL),
    .REG_COUNT    (REG_COUNT),
    .START_OFFSET (START_OFFSET),
    .WB_OFFSET    (WB_OFFSET)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic release_cmd();
    LSM_EN = 1'b0;
    LSM_IN = LSM_HOLD;
  endtask

  task automatic drive(input logic [2:0] cmd);
    LSM_EN = 1'b1;
    LSM_IN = cmd;
  endtask

  function automatic logic [31:0] make_ir(input logic [15:0] lst, input logic p, input logic u);
    return {7'd0, p, u, 7'd0, lst};
  endfunction

  task automatic wait_detect(input string tag, output int lat);
    lat = 0;
    while (lat < 40) begin
      step();
      release_cmd();
      lat++;
      if (LSM_DETECT) break;
    end
    check({tag, "_detect_seen"}, {31'd0, LSM_DETECT}, 32'd1);
  endtask

  // Expected register order and per-transfer latency from the list contents
  task automatic push_expected(input logic [15:0] lst);
    int prev;
    exp_t e;
    prev = -1;
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        e.sel = i;
        if (FAST)          e.lat = 2;
        else if (prev < 0) e.lat = i + 2;
        else               e.lat = i - prev + 1;
        sb.push_back(e);
        prev = i;
      end
    end
  endtask

  task automatic run_seq(input string name, input logic [15:0] lst, input logic p,
                         input logic u, input logic [7:0] exp_off);
    exp_t e;
    int   lat;
    bit   first;
    int   cnt;
    cnt = $countones(lst);
    push_expected(lst);
    IR = make_ir(lst, p, u);
    drive(LSM_START);
    first = 1'b1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_detect(name, lat);
      if (!LSM_DETECT) begin
        sb.delete();
        break;
      end
      check({name, "_reg_sel"}, {28'd0, REG_SEL}, e.sel);
      check({name, "_latency"}, lat, e.lat);
      if (first) begin
        check({name, "_reg_count"}, {27'd0, REG_COUNT}, cnt);
        check({name, "_wb_offset"}, {25'd0, WB_OFFSET}, 4 * cnt);
        check({name, "_start_offset"}, {24'd0, START_OFFSET}, {24'd0, exp_off});
        first = 1'b0;
      end
      step();
      drive(LSM_NEXT);
    end
    lat = 0;
    while (lat < 4) begin
      step();
      release_cmd();
      lat++;
      if (LSM_END) break;
    end
    check({name, "_end_within_2"}, {31'd0, (LSM_END && lat <= 2)}, 32'd1);
    check({name, "_end_no_detect"}, {31'd0, LSM_DETECT}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    RESET = 1'b1;
    IR    = 32'd0;
    release_cmd();
    step();
    step();
    check("rst_detect", {31'd0, LSM_DETECT}, 32'd0);
    check("rst_end", {31'd0, LSM_END}, 32'd0);
    check("rst_reg_sel", {28'd0, REG_SEL}, 32'd0);
    check("rst_reg_count", {27'd0, REG_COUNT}, 32'd0);
    check("rst_start_offset", {24'd0, START_OFFSET}, 32'd0);
    check("rst_wb_offset", {25'd0, WB_OFFSET}, 32'd0);
    RESET = 1'b0;
    step();

    // Empty list in IA
    IR = make_ir(16'h0000, 1'b0, 1'b1);
    drive(LSM_START);
    step();
    release_cmd();
    check("empty_detect_c1", {31'd0, LSM_DETECT}, 32'd0);
    step();
    check("empty_detect_c2", {31'd0, LSM_DETECT}, 32'd0);
    check("empty_end", {31'd0, LSM_END}, 32'd1);
    check("empty_reg_count", {27'd0, REG_COUNT}, 32'd0);
    check("empty_wb_offset", {25'd0, WB_OFFSET}, 32'd0);
    check("empty_start_offset", {24'd0, START_OFFSET}, 32'd0);

    run_seq("ia_8005", 16'h8005, 1'b0, 1'b1, 8'h00);
    run_seq("db_00f0", 16'h00F0, 1'b1, 1'b0, 8'hF0);
    run_seq("da_00f0", 16'h00F0, 1'b0, 1'b0, 8'hF4);
    run_seq("ib_0003", 16'h0003, 1'b1, 1'b1, 8'h04);
    run_seq("ia_8001", 16'h8001, 1'b0, 1'b1, 8'h00);

    // Abort while a register is presented
    IR = make_ir(16'h0004, 1'b0, 1'b1);
    drive(LSM_START);
    wait_detect("abort_pre", lat);
    check("abort_pre_sel", {28'd0, REG_SEL}, 32'd2);
    check("abort_pre_lat", lat, FAST ? 2 : 4);
    drive(LSM_ABORT);
    step();
    release_cmd();
    check("abort_detect", {31'd0, LSM_DETECT}, 32'd0);
    check("abort_end", {31'd0, LSM_END}, 32'd0);
    step();
    check("abort_idle_detect", {31'd0, LSM_DETECT}, 32'd0);
    check("abort_idle_end", {31'd0, LSM_END}, 32'd0);
    run_seq("abort_restart", 16'h0001, 1'b0, 1'b1, 8'h00);

    // NEXT with LSM_EN low must not advance
    IR = make_ir(16'h0030, 1'b0, 1'b1);
    drive(LSM_START);
    wait_detect("hold_pre", lat);
    check("hold_pre_sel", {28'd0, REG_SEL}, 32'd4);
    LSM_EN = 1'b0;
    LSM_IN = LSM_NEXT;
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold_detect", {31'd0, LSM_DETECT}, 32'd1);
      check("hold_sel", {28'd0, REG_SEL}, 32'd4);
    end
    drive(LSM_NEXT);
    wait_detect("hold_post", lat);
    check("hold_post_sel", {28'd0, REG_SEL}, 32'd5);
    check("hold_post_lat", lat, 2);
    drive(LSM_NEXT);
    step();
    release_cmd();
    step();
    check("hold_end", {31'd0, LSM_END}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
